// File: rtl/simon_loader.sv
// simon_loader: byte-stream front end for the Simon 64/128 core.
// Assembles big-endian key (128b) and block (64b) frames from a valid/ready
// byte stream. It issues one valid_in pulse per block and then waits for
// core_done or a timeout. The key persists across blocks until a new key frame.
module simon_loader #(
  parameter int unsigned KEY_BYTES   = 16,
  parameter int unsigned BLOCK_BYTES = 8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [7:0]   s_data,
  input  logic         s_kind,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         core_done,
  output logic [127:0] key,
  output logic [63:0]  in_block,
  output logic         valid_in,
  output logic         key_loaded,
  output logic         busy,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  KEY_LAST = 4'(KEY_BYTES - 1);
  localparam logic [3:0]  BLK_LAST = 4'(BLOCK_BYTES - 1);
  // ISSUE is cycle 0 of the wait window. The last WAIT cycle is
  // therefore the one where timer_q == TIMEOUT-2.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_BLK,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   sh_q, sh_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic [63:0]    blk_q, blk_d;
  logic           key_loaded_q, key_loaded_d;
  logic           s_ready_q, s_ready_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      key_q        <= '0;
      blk_q        <= '0;
      key_loaded_q <= 1'b0;
      s_ready_q    <= 1'b0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      blk_q        <= blk_d;
      key_loaded_q <= key_loaded_d;
      s_ready_q    <= s_ready_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    blk_d        = blk_q;
    key_loaded_d = key_loaded_q;
    timer_d      = timer_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    accept       = s_valid && s_ready_q;

    if (accept) begin
      sh_d = {sh_q[119:0], s_data};
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = 4'd1;
          state_d = s_kind ? S_LOAD_KEY : S_LOAD_BLK;
        end
      end
      S_LOAD_KEY: begin
        if (accept) begin
          if (!s_kind) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            cnt_d      = 4'd1;
            state_d    = S_LOAD_BLK;
          end else if (cnt_q == KEY_LAST) begin
            key_d        = sh_d;
            key_loaded_d = 1'b1;
            cnt_d        = '0;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_LOAD_BLK: begin
        if (accept) begin
          if (s_kind) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            cnt_d      = 4'd1;
            state_d    = S_LOAD_KEY;
          end else if (cnt_q == BLK_LAST) begin
            cnt_d = '0;
            if (key_loaded_q) begin
              blk_d   = sh_d[63:0];
              state_d = S_ISSUE;
            end else begin
              err_d      = 1'b1;
              err_code_d = 2'd2;
              state_d    = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = core_done ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (core_done) begin
          state_d = S_IDLE;
        end else if (timer_q == TMO_LAST) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_KEY) ||
                (state_d == S_LOAD_BLK);
  end

  always_comb begin
    valid_in   = (state_q == S_ISSUE);
    busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    s_ready    = s_ready_q;
    key        = key_q;
    in_block   = blk_q;
    key_loaded = key_loaded_q;
    err        = err_q;
    err_code   = err_code_q;
  end

endmodule

// File: doc/simon_loader.md
# simon_loader

Byte-stream front end for the Simon 64/128 encryption core. It takes key and plaintext bytes over a valid/ready byte interface and assembles them into the 128-bit key and 64-bit block. It issues one single-cycle `valid_in` start pulse per block to the core, then holds off further input until the core reports completion or a timeout expires. The key is sticky: once loaded, it is reused for every following block until a new key frame replaces it.

## Interface
- `KEY_BYTES`, 16: bytes per key frame. Only 16 is supported.
- `BLOCK_BYTES`, 8: bytes per block frame. Only 8 is supported.
- `TIMEOUT`, 255: maximum cycles to wait for `core_done` after `valid_in`.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `s_data` input 8: stream byte.
- `s_kind` input 1: byte type, 1 = key byte, 0 = block byte.
- `s_valid` input 1: byte present.
- `s_ready` output 1: loader accepts a byte this cycle. Registered.
- `core_done` input 1: single-cycle pulse from the core when the block result is produced.
- `key` output 128: committed key.
- `in_block` output 64: committed plaintext block.
- `valid_in` output 1: single-cycle start pulse to the core.
- `key_loaded` output 1: a complete key has been committed since reset.
- `busy` output 1: high while the core is in flight (states ISSUE, WAIT).
- `err` output 1: single-cycle error pulse.
- `err_code` output 2: cause, valid while `err` = 1 and held until the next error.
  - 1 = kind changed mid-frame.
  - 2 = block frame completed with no key loaded.
  - 3 = timeout.

## Operation
- States: IDLE, LOAD_KEY, LOAD_BLK, ISSUE, WAIT.
- A byte is accepted on a rising edge with `s_valid` & `s_ready`.
- `s_ready` = 1 in IDLE, LOAD_KEY and LOAD_BLK; 0 in ISSUE and WAIT.
- Byte order is big-endian. The first byte of a frame lands in the MSB: shift register `sh <= {sh, s_data}`. A 4-bit counter tracks bytes accepted in the current frame.
- IDLE: an accepted byte starts a frame (count = 1) and moves to LOAD_KEY or LOAD_BLK according to `s_kind`.
- LOAD_KEY: on the 16th byte, `key` <= assembled value, `key_loaded` <= 1, go to IDLE. Partial frames never modify `key`.
- LOAD_BLK: on the 8th byte:
  - if `key_loaded`: `in_block` <= assembled value, go to ISSUE;
  - else: drop the frame, pulse `err` with code 2, go to IDLE.
- Kind switch mid-frame: an accepted byte whose `s_kind` differs from the current frame discards the partial frame and pulses `err` with code 1. That byte becomes byte 1 of a new frame of its own kind. State moves to the matching LOAD state.
- ISSUE: `valid_in` = 1 for this one cycle. Timer is cleared. Go to WAIT, or to IDLE if `core_done` = 1 in this same cycle.
- WAIT: timer increments each cycle.
  - `core_done` = 1: go to IDLE.
  - Timer reaches `TIMEOUT` with no `core_done`: pulse `err` with code 3, go to IDLE.
  - `core_done` in the same cycle the timeout is reached counts as done, with no error.
- `core_done` outside ISSUE/WAIT is ignored.
- A new key frame while a block is in flight is impossible, because `s_ready` = 0.

## Timing
- Reset (asynchronous, `rstn` = 0) forces every output and internal register to 0, including `s_ready`, `key`, `in_block`, `key_loaded`, `err_code` and the timer. State returns to IDLE.
- Reset asserted mid-frame or mid-flight abandons all work and clears the key.
- `s_ready` rises on the first rising edge after `rstn` deasserts.
- Last block byte accepted at edge N: `in_block` is valid and `valid_in` = 1 in cycle N+1. `s_ready` = 0 from cycle N+1.
- `core_done` sampled at edge M: state is IDLE and `s_ready` = 1 in cycle M+1.
- Last key byte accepted at edge N: `key` and `key_loaded` are updated in cycle N+1, and `s_ready` stays 1. Back-to-back frames run at one byte per cycle with no bubble.
- `err` is asserted in the cycle after the offending edge and lasts exactly one cycle.
- `in_block` and `key` hold their values until the next commit.

## Test plan
- Key bytes 1b 1a 19 18 13 12 11 10 0b 0a 09 08 03 02 01 00, one per cycle -> `key` = 128'h1b1a1918131211100b0a090803020100, `key_loaded` = 1, no `valid_in`.
- Then block bytes 65 6b 69 6c 20 64 6e 75 -> `in_block` = 64'h656b696c20646e75, one `valid_in` pulse, `s_ready` = 0. `core_done` 40 cycles later -> `s_ready` = 1 next cycle. Core output checks 64'h44c8fc20b9dfa07a.
- Block frame after reset with no key -> no `valid_in`, `err` = 1 with `err_code` = 2, `in_block` stays 0.
- Key frame cut after 5 bytes by a block byte -> `err` code 1, `key` unchanged. The new block frame completes normally with 8 bytes total.
- `valid_in` issued, `core_done` never arrives -> `err` code 3 exactly 255 cycles after ISSUE, then IDLE with `s_ready` = 1.
- `rstn` pulled low during WAIT -> outputs 0 immediately. After release, a block frame yields `err` code 2, because the key was cleared.
